level_meter_arbiter: RTL and testbench
======================================

Name: level_meter_arbiter

Overview:
- Round-robin arbiter that shares one display/serialiser output stream between channel_count level-meter channel pipelines (e.g. left/right).
- Each channel offers an indicator bar array over a valid/ready handshake. The arbiter grants one channel at a time, registers the array with its channel index, and presents it downstream on a single valid/ready port.
- Full throughput: one transfer per cycle when downstream is always ready. No channel starves.

Parameters:
channel_count, 2, number of requesting channels; must be >= 2
indicator_width, 32, bar array width per channel, in bits

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_valid  input  channel_count  per-channel array valid
i_ready  output  channel_count  per-channel accept; at most one bit high per cycle
i_array  input  channel_count*indicator_width  packed arrays; channel c occupies [c*indicator_width +: indicator_width]
o_valid  output  1  output register holds a granted array
o_ready  input  1  downstream accept
o_channel  output  $clog2(channel_count)  index of the channel held in the output register
o_array  output  indicator_width  held bar array

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: o_valid=0, o_channel=0, o_array=0, round-robin pointer ptr=0. i_ready=0 (all bits) whenever reset=1.
- State: the output register is EMPTY (o_valid=0) or FULL (o_valid=1).
- Accept condition: can_load = EMPTY | (FULL & o_ready).
  - i_ready is combinational from i_valid, ptr, state and o_ready.
  - The o_ready -> i_ready path is a deliberate combinational path.
- Grant selection:
  - When can_load=1, g is the first index with i_valid set, searching ptr, ptr+1, ..., channel_count-1, 0, ..., ptr-1 (modulo wrap).
  - i_ready[g]=1; all other bits are 0.
  - If no i_valid bit is set, i_ready=0.
- On an input handshake (i_valid[g] & i_ready[g]):
  - o_array <= i_array slice g; o_channel <= g; o_valid <= 1.
  - ptr <= g+1, wrapping to 0 when g = channel_count-1.
- On an output handshake (o_valid & o_ready) with no simultaneous input handshake: o_valid <= 0. o_channel and o_array keep their last values.
- Simultaneous output and input handshake: the register is reloaded and o_valid stays 1. This gives back-to-back transfers with no bubble.
- FULL & !o_ready:
  - o_valid, o_channel and o_array are stable; i_ready=0.
  - ptr does not change.
- Latency: an input handshake at edge N gives o_valid=1 with the data after edge N.
- i_array is sampled only on the handshake edge. Inputs may change while i_ready=0.
- A channel may drop i_valid without a handshake; it is then skipped with no side effect.
- Fairness: with all channels continuously valid and o_ready=1, grants cycle 0,1,...,channel_count-1,0,...
  - A continuously valid channel is granted within channel_count output handshakes.
- Reset asserted mid-operation: on the next edge, a held word is discarded (o_valid=0) and ptr=0. No i_ready is asserted while reset=1.
- Width rule: ptr and o_channel are $clog2(channel_count) bits. When channel_count is not a power of two, the wrap is an explicit compare, not an overflow.

Test Plan:
- Reset: hold reset 3 cycles with all i_valid=1 and o_ready=1 -> i_ready=0 and o_valid=0 throughout; after reset release, the first grant is channel 0.
- Single requester: channel 1 only, i_valid[1]=1, i_array[1]=32'h0000_00FF, o_ready=1 -> i_ready=2'b10; one cycle later o_valid=1, o_channel=1, o_array=32'h0000_00FF; back-to-back transfers every cycle.
- Both channels always valid, o_ready=1, channel_count=2 -> o_channel sequence is 0,1,0,1,... with o_valid continuously 1 after the first cycle.
- Backpressure: o_ready=0 for 5 cycles while FULL -> o_valid, o_channel and o_array stable; i_ready=0; ptr unchanged. On o_ready=1, the next grant goes to the channel after the held one.
- Wrap with channel_count=3: only channels 0 and 2 valid -> grants alternate 0,2,0,2; channel 1 is raised after a grant to 2 -> the next grant is 0, then 1.
- Reset mid-hold: FULL with o_ready=0, then assert reset for 1 cycle -> o_valid=0 and o_array=0 after that edge. After release with all channels valid, the first grant is channel 0.

Source files
------------

// File: rtl/level_meter_arbiter_if.sv
// level_meter_arbiter_if: per-channel request bundle plus the single shared output stream
interface level_meter_arbiter_if #(
  parameter int channel_count = 2,
  parameter int indicator_width = 32
);
  logic [channel_count-1:0] i_valid;
  logic [channel_count-1:0] i_ready;
  logic [channel_count*indicator_width-1:0] i_array;
  logic o_valid;
  logic o_ready;
  logic [$clog2(channel_count)-1:0] o_channel;
  logic [indicator_width-1:0] o_array;
  modport master (
    output i_valid, i_array, o_ready,
    input  i_ready, o_valid, o_channel, o_array
  );
  modport slave (
    input  i_valid, i_array, o_ready,
    output i_ready, o_valid, o_channel, o_array
  );
endinterface

// File: rtl/level_meter_arbiter.sv
// level_meter_arbiter: round-robin share of one registered output stream between level-meter channels
module level_meter_arbiter #(
  parameter int channel_count = 2,
  parameter int indicator_width = 32
) (
  input logic clk,
  input logic reset,
  level_meter_arbiter_if.slave bus
);
  localparam int cw = $clog2(channel_count);
  logic [cw-1:0] ptr;
  logic [cw-1:0] g;
  logic found;
  logic take;
  // modulo add via explicit compare so non-power-of-two counts wrap correctly
  function automatic logic [cw-1:0] rot(input logic [cw-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return cw'(s >= channel_count ? s - channel_count : s);
  endfunction
  always_comb begin
    g = '0;
    found = 1'b0;
    for (int k = 0; k < channel_count; k++)
      if (!found && bus.i_valid[rot(ptr, k)]) begin
        found = 1'b1;
        g = rot(ptr, k);
      end
    take = !reset && (!bus.o_valid || bus.o_ready) && found;
    bus.i_ready = take ? {{(channel_count-1){1'b0}}, 1'b1} << g : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.o_valid <= 1'b0;
      bus.o_channel <= '0;
      bus.o_array <= '0;
      ptr <= '0;
    end else if (take) begin
      bus.o_valid <= 1'b1;
      bus.o_channel <= g;
      bus.o_array <= bus.i_array[g*indicator_width +: indicator_width];
      ptr <= (g == cw'(channel_count-1)) ? '0 : g + 1'b1;
    end else if (bus.o_ready) begin
      bus.o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_level_meter_arbiter.sv
// tb_level_meter_arbiter: randomized and directed stimulus on 2- and 3-channel arbiters against a queue-free reference model
module tb_level_meter_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] data [3];
  int mptr [2];
  int mch [2];
  logic mv [2];
  logic [31:0] marr [2];
  level_meter_arbiter_if #(.channel_count(2), .indicator_width(32)) bus2 ();
  level_meter_arbiter_if #(.channel_count(3), .indicator_width(32)) bus3 ();
  level_meter_arbiter #(.channel_count(2), .indicator_width(32)) u2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  level_meter_arbiter #(.channel_count(3), .indicator_width(32)) u3 (.clk(clk), .reset(reset), .bus(bus3.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input int d, input int n, input logic [2:0] vm, input logic ordy,
                       input logic [2:0] rdy_got, input logic ov, input logic [1:0] ch, input logic [31:0] arr);
    int g;
    logic [2:0] er;
    g = -1;
    for (int k = 0; k < n; k++)
      if (g < 0 && vm[(mptr[d] + k) % n]) g = (mptr[d] + k) % n;
    er = (!reset && (!mv[d] || ordy) && g >= 0) ? 3'(1 << g) : 3'b000;
    check($sformatf("n%0d_i_ready", n), 32'(rdy_got), 32'(er));
    check($sformatf("n%0d_o_valid", n), 32'(ov), 32'(mv[d]));
    check($sformatf("n%0d_o_channel", n), 32'(ch), 32'(mch[d]));
    check($sformatf("n%0d_o_array", n), arr, marr[d]);
    if (reset) begin
      mv[d] = 1'b0; mch[d] = 0; marr[d] = '0; mptr[d] = 0;
    end else if (er != 3'b000) begin
      mv[d] = 1'b1; mch[d] = g; marr[d] = data[g]; mptr[d] = (g + 1) % n;
    end else if (ordy) begin
      mv[d] = 1'b0;
    end
  endtask
  task automatic step(input logic r, input logic [2:0] v, input logic r2, input logic r3);
    @(negedge clk);
    reset = r;
    bus2.i_valid = v[1:0];
    bus2.i_array = {data[1], data[0]};
    bus2.o_ready = r2;
    bus3.i_valid = v;
    bus3.i_array = {data[2], data[1], data[0]};
    bus3.o_ready = r3;
    #1;
    model(0, 2, {1'b0, v[1:0]}, r2, {1'b0, bus2.i_ready}, bus2.o_valid, {1'b0, bus2.o_channel}, bus2.o_array);
    model(1, 3, v, r3, bus3.i_ready, bus3.o_valid, bus3.o_channel, bus3.o_array);
  endtask
  task automatic scramble();
    for (int c = 0; c < 3; c++) data[c] = $urandom;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0; mch[d] = 0; mv[d] = 1'b0; marr[d] = '0;
    end
    for (int c = 0; c < 3; c++) data[c] = '0;
    bus2.i_valid = '0; bus2.i_array = '0; bus2.o_ready = 1'b0;
    bus3.i_valid = '0; bus3.i_array = '0; bus3.o_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin scramble(); step(1'b1, 3'b111, 1'b1, 1'b1); end
    scramble(); step(1'b0, 3'b111, 1'b1, 1'b1);
    check("first_grant_n2", 32'(bus2.i_ready), 32'd1);
    check("first_grant_n3", 32'(bus3.i_ready), 32'd1);
    data[1] = 32'h0000_00FF;
    for (int i = 0; i < 4; i++) step(1'b0, 3'b010, 1'b1, 1'b1);
    check("single_ch1_array", bus2.o_array, 32'h0000_00FF);
    check("single_ch1_channel", 32'(bus2.o_channel), 32'd1);
    for (int i = 0; i < 8; i++) begin scramble(); step(1'b0, 3'b111, 1'b1, 1'b1); end
    for (int i = 0; i < 5; i++) begin scramble(); step(1'b0, 3'b111, 1'b0, 1'b0); end
    for (int i = 0; i < 3; i++) begin scramble(); step(1'b0, 3'b111, 1'b1, 1'b1); end
    for (int i = 0; i < 4; i++) begin scramble(); step(1'b0, 3'b101, 1'b1, 1'b1); end
    for (int i = 0; i < 4; i++) begin scramble(); step(1'b0, 3'b111, 1'b1, 1'b1); end
    for (int i = 0; i < 2; i++) begin scramble(); step(1'b0, 3'b111, 1'b0, 1'b0); end
    scramble(); step(1'b1, 3'b111, 1'b0, 1'b0);
    scramble(); step(1'b0, 3'b111, 1'b1, 1'b1);
    check("post_reset_grant_n3", 32'(bus3.i_ready), 32'd1);
    for (int i = 0; i < 2000; i++) begin
      scramble();
      step(($urandom_range(0, 99) == 0), 3'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
